// File: rtl/width_param.sv
// rtl/width_param.sv - shared datapath widths for the writeback stage
package width_param;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int REG_WIDTH  = 5;
endpackage

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: retires MEM instructions, waits for load data
module wb_stage
  import width_param::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_pc,
  input  logic [INST_WIDTH-1:0] mem_inst,
  input  logic                  mem_ram_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rw_data,
  input  logic [REG_WIDTH-1:0]  mem_rw_addr,
  input  logic                  mem_rw_en,
  input  logic                  ram_rdata_valid,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  flush,
  output logic                  reg_we,
  output logic [REG_WIDTH-1:0]  reg_waddr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  commit_valid,
  output logic [ADDR_WIDTH-1:0] commit_pc,
  output logic [INST_WIDTH-1:0] commit_inst,
  output logic [7:0]            load_wait_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, COMMIT} state_t;

  state_t                state, state_next;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [REG_WIDTH-1:0]  rw_addr_q, rw_addr_d;
  logic                  rw_en_q, rw_en_d;
  logic [DATA_WIDTH-1:0] rw_data_q, rw_data_d;
  logic [7:0]            cnt_d;
  logic                  entering_commit;

  assign mem_ready       = (state == IDLE) || (state == COMMIT);
  assign transfer        = mem_valid && mem_ready && !flush;
  assign entering_commit = (state_next == COMMIT);

  always_comb begin
    state_next = state;
    pc_d       = pc_q;
    inst_d     = inst_q;
    rw_addr_d  = rw_addr_q;
    rw_en_d    = rw_en_q;
    rw_data_d  = rw_data_q;
    cnt_d      = load_wait_cnt;
    case (state)
      IDLE, COMMIT: begin
        if (transfer) begin
          pc_d      = mem_pc;
          inst_d    = mem_inst;
          rw_addr_d = mem_rw_addr;
          rw_en_d   = mem_rw_en;
          rw_data_d = mem_rw_data;
          if (mem_ram_rd_en) begin
            state_next = WAIT;
            cnt_d      = 8'd0;
          end else begin
            state_next = COMMIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (load_wait_cnt != 8'hFF) cnt_d = load_wait_cnt + 8'd1;
        if (ram_rdata_valid && !flush) begin
          rw_data_d  = ram_rdata;
          state_next = COMMIT;
        end else if (flush && ram_rdata_valid) begin
          state_next = IDLE;
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      // A killed load still owes us one data beat; swallow it before accepting more.
      DRAIN: begin
        if (ram_rdata_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= '0;
      inst_q        <= '0;
      rw_addr_q     <= '0;
      rw_en_q       <= 1'b0;
      rw_data_q     <= '0;
      load_wait_cnt <= 8'd0;
      reg_we        <= 1'b0;
      reg_waddr     <= '0;
      reg_wdata     <= '0;
      commit_valid  <= 1'b0;
      commit_pc     <= '0;
      commit_inst   <= '0;
    end else begin
      state         <= state_next;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      rw_addr_q     <= rw_addr_d;
      rw_en_q       <= rw_en_d;
      rw_data_q     <= rw_data_d;
      load_wait_cnt <= cnt_d;
      commit_valid  <= entering_commit;
      reg_we        <= entering_commit && rw_en_d && (rw_addr_d != '0);
      if (entering_commit) begin
        reg_waddr   <= rw_addr_d;
        reg_wdata   <= rw_data_d;
        commit_pc   <= pc_d;
        commit_inst <= inst_d;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;
  import width_param::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_pc;
  logic [INST_WIDTH-1:0] mem_inst;
  logic                  mem_ram_rd_en;
  logic [DATA_WIDTH-1:0] mem_rw_data;
  logic [REG_WIDTH-1:0]  mem_rw_addr;
  logic                  mem_rw_en;
  logic                  ram_rdata_valid;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  flush;
  logic                  reg_we;
  logic [REG_WIDTH-1:0]  reg_waddr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  commit_valid;
  logic [ADDR_WIDTH-1:0] commit_pc;
  logic [INST_WIDTH-1:0] commit_inst;
  logic [7:0]            load_wait_cnt;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  we;
    logic [REG_WIDTH-1:0]  waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  wb_stage dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_ram_rd_en(mem_ram_rd_en),
    .mem_rw_data(mem_rw_data), .mem_rw_addr(mem_rw_addr), .mem_rw_en(mem_rw_en),
    .ram_rdata_valid(ram_rdata_valid), .ram_rdata(ram_rdata), .flush(flush),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .load_wait_cnt(load_wait_cnt)
  );

  always #5 clk = ~clk;

  // Commit monitor: every retire must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (commit_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got pc=%h inst=%h, required no commit", commit_pc, commit_inst);
      end else begin
        e = q.pop_front();
        if ({commit_pc, commit_inst} !== {e.pc, e.inst}) begin
          errors++;
          $display("FAIL commit_id: got pc=%h inst=%h, required pc=%h inst=%h", commit_pc, commit_inst, e.pc, e.inst);
        end
        checks++;
        if ({reg_we, reg_waddr, reg_wdata} !== {e.we, e.waddr, e.wdata}) begin
          errors++;
          $display("FAIL reg_write: got we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                   reg_we, reg_waddr, reg_wdata, e.we, e.waddr, e.wdata);
        end
      end
    end else begin
      checks++;
      if (reg_we !== 1'b0) begin
        errors++;
        $display("FAIL reg_we_outside_commit: got %b, required 0", reg_we);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; mem_pc = '0; mem_inst = '0; mem_ram_rd_en = 0;
    mem_rw_data = '0; mem_rw_addr = '0; mem_rw_en = 0;
    ram_rdata_valid = 0; ram_rdata = '0; flush = 0;
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [31:0] inst, input logic load,
                          input logic [4:0] addr, input logic en, input logic [31:0] data);
    mem_valid = 1; mem_pc = pc; mem_inst = inst; mem_ram_rd_en = load;
    mem_rw_addr = addr; mem_rw_en = en; mem_rw_data = data;
  endtask

  task automatic expect_commit(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [4:0] addr, input logic en, input logic [31:0] data);
    exp_t e;
    e.pc = pc; e.inst = inst; e.waddr = addr; e.wdata = data;
    e.we = en && (addr != 5'd0);
    q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    step(); step();
    rst = 0;
    checks++;
    if ({mem_ready, reg_we, commit_valid, load_wait_cnt, commit_pc, reg_wdata} !== {1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b we=%b cv=%b cnt=%0d pc=%h wdata=%h, required 1 0 0 0 0 0",
               mem_ready, reg_we, commit_valid, load_wait_cnt, commit_pc, reg_wdata);
    end
  endtask

  task automatic test_alu();
    drive_op(32'h1C000000, 32'h00A28293, 0, 5'd5, 1, 32'hDEADBEEF);
    expect_commit(32'h1C000000, 32'h00A28293, 5'd5, 1, 32'hDEADBEEF);
    step();
    clear_inputs();
    checks++;
    if ({commit_valid, reg_we, reg_waddr} !== {1'b1, 1'b1, 5'd5}) begin
      errors++;
      $display("FAIL alu_latency: got cv=%b we=%b waddr=%0d, required 1 1 5", commit_valid, reg_we, reg_waddr);
    end
    step();
    checks++;
    if ({commit_valid, reg_waddr, reg_wdata, commit_pc} !== {1'b0, 5'd5, 32'hDEADBEEF, 32'h1C000000}) begin
      errors++;
      $display("FAIL alu_hold: got cv=%b waddr=%0d wdata=%h pc=%h, required 0 5 deadbeef 1c000000",
               commit_valid, reg_waddr, reg_wdata, commit_pc);
    end
  endtask

  task automatic test_load();
    drive_op(32'h1C000010, 32'h0003A383, 1, 5'd7, 1, 32'h0000AAAA);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_ready_wait%0d: got %b, required 0", i, mem_ready);
      end
      if (i == 2) begin
        ram_rdata_valid = 1; ram_rdata = 32'h12345678;
        expect_commit(32'h1C000010, 32'h0003A383, 5'd7, 1, 32'h12345678);
      end
      step();
    end
    clear_inputs();
    checks++;
    if ({commit_valid, mem_ready, load_wait_cnt, reg_wdata} !== {1'b1, 1'b1, 8'd3, 32'h12345678}) begin
      errors++;
      $display("FAIL load_commit: got cv=%b ready=%b cnt=%0d wdata=%h, required 1 1 3 12345678",
               commit_valid, mem_ready, load_wait_cnt, reg_wdata);
    end
    step();
  endtask

  task automatic test_r0();
    drive_op(32'h1C000020, 32'h00100013, 0, 5'd0, 1, 32'h0BADF00D);
    expect_commit(32'h1C000020, 32'h00100013, 5'd0, 1, 32'h0BADF00D);
    step();
    clear_inputs();
    checks++;
    if ({commit_valid, reg_we} !== 2'b10) begin
      errors++;
      $display("FAIL r0_write: got cv=%b we=%b, required cv=1 we=0", commit_valid, reg_we);
    end
    step();
  endtask

  task automatic test_flush_load();
    drive_op(32'h1C000030, 32'h00042403, 1, 5'd8, 1, 32'h0);
    step();
    clear_inputs();
    flush = 1;
    step();
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain_ready: got %b, required 0", mem_ready);
    end
    step();
    flush = 0;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_holds_under_flush: got %b, required 0", mem_ready);
    end
    ram_rdata_valid = 1; ram_rdata = 32'hCAFECAFE;
    step();
    clear_inputs();
    checks++;
    if ({mem_ready, commit_valid, reg_we} !== 3'b100) begin
      errors++;
      $display("FAIL drain_to_idle: got ready=%b cv=%b we=%b, required 1 0 0", mem_ready, commit_valid, reg_we);
    end
    drive_op(32'h1C000034, 32'h00942423, 1, 5'd9, 1, 32'h0);
    step();
    clear_inputs();
    flush = 1; ram_rdata_valid = 1; ram_rdata = 32'h55555555;
    step();
    clear_inputs();
    checks++;
    if ({mem_ready, commit_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_with_data: got ready=%b cv=%b, required 1 0", mem_ready, commit_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_op(32'h1C000100 + 32'(i * 4), 32'h00000013 + 32'(i), 0, 5'(i + 1), 1, 32'hA0000000 + 32'(i));
      expect_commit(32'h1C000100 + 32'(i * 4), 32'h00000013 + 32'(i), 5'(i + 1), 1, 32'hA0000000 + 32'(i));
      step();
      checks++;
      if (commit_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_commit%0d: got %b, required 1", i, commit_valid);
      end
    end
    clear_inputs();
    step();
    for (int i = 0; i < 2; i++) begin
      drive_op(32'h1C000200 + 32'(i * 4), 32'h00000113 + 32'(i), 0, 5'(i + 10), 1, 32'hB0000000 + 32'(i));
      expect_commit(32'h1C000200 + 32'(i * 4), 32'h00000113 + 32'(i), 5'(i + 10), 1, 32'hB0000000 + 32'(i));
      step();
    end
    drive_op(32'h1C000208, 32'h00000115, 0, 5'd12, 1, 32'hB0000002);
    flush = 1;
    checks++;
    if ({commit_valid, commit_pc} !== {1'b1, 32'h1C000204}) begin
      errors++;
      $display("FAIL flush_commit_kept: got cv=%b pc=%h, required 1 1c000204", commit_valid, commit_pc);
    end
    step();
    clear_inputs();
    checks++;
    if (commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: got cv=%b, required 0", commit_valid);
    end
    step();
  endtask

  task automatic test_saturation();
    drive_op(32'h1C000300, 32'h00052503, 1, 5'd10, 1, 32'h0);
    step();
    clear_inputs();
    for (int i = 0; i < 300; i++) step();
    ram_rdata_valid = 1; ram_rdata = 32'h77777777;
    expect_commit(32'h1C000300, 32'h00052503, 5'd10, 1, 32'h77777777);
    step();
    clear_inputs();
    checks++;
    if ({commit_valid, load_wait_cnt} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL wait_cnt_saturate: got cv=%b cnt=%0d, required 1 255", commit_valid, load_wait_cnt);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    drive_op(32'h1C000400, 32'h0005A583, 1, 5'd11, 1, 32'h0);
    step();
    clear_inputs();
    step();
    rst = 1;
    step();
    rst = 0;
    ram_rdata_valid = 1; ram_rdata = 32'h99999999;
    checks++;
    if ({mem_ready, reg_we, commit_valid, reg_waddr, reg_wdata, commit_pc, commit_inst, load_wait_cnt} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_in_wait: got ready=%b we=%b cv=%b waddr=%0d wdata=%h pc=%h inst=%h cnt=%0d, required 1 and all zero",
               mem_ready, reg_we, commit_valid, reg_waddr, reg_wdata, commit_pc, commit_inst, load_wait_cnt);
    end
    step();
    clear_inputs();
    checks++;
    if ({mem_ready, commit_valid} !== 2'b10) begin
      errors++;
      $display("FAIL late_rdata_ignored: got ready=%b cv=%b, required 1 0", mem_ready, commit_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_r0();
    test_flush_load();
    test_back_to_back();
    test_saturation();
    test_reset_in_wait();
    step(); step();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
